serial_adder_ctrl: RTL



---
 rtl/serial_adder_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder built around one shared 1-bit full adder.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset
//   Start - operation request, accepted in IDLE or DONE
//   A, B  - operands, latched on an accepted Start
//   Cin   - initial carry-in, latched on an accepted Start
//   Busy  - high while the bit-serial addition is running
//   Done  - one-cycle pulse when Sum/Cout carry a new result
//   Sum   - registered result, A + B + Cin modulo 2^WIDTH
//   Cout  - registered carry out of bit WIDTH-1
//
// full_adder: purely combinational one-bit full adder shared by the controller.
//   A, B, Cin - addend bits and carry-in
//   Sum, Cout - sum bit and carry-out

module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int unsigned IdxW = $clog2(WIDTH + 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             fa_sum;
    logic             fa_cout;
    logic [WIDTH-1:0] acc_shift;

    full_adder u_full_adder (
        .A    (opa_q[0]),
        .B    (opb_q[0]),
        .Cin  (carry_q),
        .Sum  (fa_sum),
        .Cout (fa_cout)
    );

    // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at acc[0].
    // The bit shifted out of acc[0] is never needed.
    generate
        if (WIDTH == 1) begin : g_acc_w1
            assign acc_shift = fa_sum;
        end else begin : g_acc_wn
            assign acc_shift = {fa_sum, acc_q[WIDTH-1:1]};
        end
    endgenerate

    logic unused_acc_lsb;
    assign unused_acc_lsb = acc_q[0];

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        carry_d = carry_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (state_q == StDone) begin
                    state_d = StIdle;
                end
                if (Start) begin
                    opa_d   = A;
                    opb_d   = B;
                    carry_d = Cin;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                carry_d = fa_cout;
                acc_d   = acc_shift;
                idx_d   = idx_q + IdxW'(1);
                if (idx_q == IdxLast) begin
                    sum_d   = acc_shift;
                    cout_d  = fa_cout;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        Busy = (state_q == StRun);
        Done = (state_q == StDone);
        Sum  = sum_q;
        Cout = cout_q;
    end

endmodule
